// File: rtl/matmul_mem_port.sv
// Word-addressed single-port SRAM behind the matmul engine's memory port.
// It also has a secondary host port. The engine always wins arbitration.
// Reads return in issue order after a fixed RD_LAT cycles.
module matmul_mem_port #(
  parameter int MEM_AW = 16,
  parameter int MEM_DW = 32,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [MEM_AW-1:0] mem_addr,
  input  logic [MEM_DW-1:0] mem_wdata,
  output logic              mem_rdata_vld,
  output logic [MEM_DW-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_write,
  input  logic [MEM_AW-1:0] host_addr,
  input  logic [MEM_DW-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rdata_vld,
  output logic [MEM_DW-1:0] host_rdata,
  output logic              addr_err,
  input  logic              err_clr,
  output logic [31:0]       rd_cnt,
  output logic [31:0]       wr_cnt,
  input  logic              cnt_clr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [MEM_AW:0] DEPTH_LIM = (MEM_AW + 1)'(DEPTH);

  logic [MEM_DW-1:0] mem_array [DEPTH];

  logic              acc_vld, acc_write, acc_src, acc_oor, acc_rd, acc_wr;
  logic [MEM_AW-1:0] acc_addr;
  logic [MEM_DW-1:0] acc_wdata;
  logic [IW-1:0]     acc_idx;

  logic [RD_LAT-1:0] vld_q, vld_d, src_q, src_d;
  logic              oor0_q, oor0_d;
  logic [MEM_DW-1:0] ram_rdata_q;
  logic [MEM_DW-1:0] stage_data [RD_LAT];

  logic              last_vld, last_src;
  logic [MEM_DW-1:0] last_data;
  logic [MEM_DW-1:0] mem_hold_q, mem_hold_d, host_hold_q, host_hold_d;
  logic              addr_err_q, addr_err_d;
  logic [31:0]       rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

  // Arbitration: the engine has no backpressure, so it always owns the array when requesting
  always_comb begin
    host_gnt  = host_req & ~mem_req;
    acc_vld   = mem_req | host_req;
    acc_src   = ~mem_req;
    acc_write = mem_req ? mem_write : host_write;
    acc_addr  = mem_req ? mem_addr  : host_addr;
    acc_wdata = mem_req ? mem_wdata : host_wdata;
    acc_oor   = {1'b0, acc_addr} >= DEPTH_LIM;
    acc_idx   = acc_addr[IW-1:0];
    acc_rd    = acc_vld & ~acc_write;
    acc_wr    = acc_vld & acc_write;
  end

  // Array write plus registered read; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (acc_wr && !acc_oor) begin
      mem_array[acc_idx] <= acc_wdata;
    end
    ram_rdata_q <= mem_array[acc_idx];
  end

  // Out-of-range reads still take a slot but return zero
  assign stage_data[0] = oor0_q ? '0 : ram_rdata_q;

  // Data stages beyond the RAM output register carry no reset; only valid bits matter
  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_stage
    logic [MEM_DW-1:0] data_q;
    always_ff @(posedge clk) begin
      data_q <= stage_data[gi-1];
    end
    assign stage_data[gi] = data_q;
  end

  // Next state for the valid/source shift register, error flag, counters and hold registers
  always_comb begin
    vld_d    = '0;
    src_d    = '0;
    vld_d[0] = acc_rd;
    src_d[0] = acc_src;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      src_d[i] = src_q[i-1];
    end
    oor0_d = acc_oor;

    last_vld  = vld_q[RD_LAT-1];
    last_src  = src_q[RD_LAT-1];
    last_data = stage_data[RD_LAT-1];

    mem_rdata_vld  = last_vld & ~last_src;
    host_rdata_vld = last_vld & last_src;
    mem_hold_d     = mem_rdata_vld  ? last_data : mem_hold_q;
    host_hold_d    = host_rdata_vld ? last_data : host_hold_q;
    mem_rdata      = mem_hold_d;
    host_rdata     = host_hold_d;

    // A new error takes precedence over a simultaneous clear
    addr_err_d = addr_err_q;
    if (err_clr) addr_err_d = 1'b0;
    if (acc_vld && acc_oor) addr_err_d = 1'b1;

    // Clear takes precedence over a simultaneous access
    rd_cnt_d = cnt_clr ? 32'd0 : rd_cnt_q + {31'd0, acc_rd};
    wr_cnt_d = cnt_clr ? 32'd0 : wr_cnt_q + {31'd0, acc_wr};
  end

  // Control state register; an asserted reset discards every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      src_q       <= '0;
      oor0_q      <= 1'b0;
      mem_hold_q  <= '0;
      host_hold_q <= '0;
      addr_err_q  <= 1'b0;
      rd_cnt_q    <= 32'd0;
      wr_cnt_q    <= 32'd0;
    end else begin
      vld_q       <= vld_d;
      src_q       <= src_d;
      oor0_q      <= oor0_d;
      mem_hold_q  <= mem_hold_d;
      host_hold_q <= host_hold_d;
      addr_err_q  <= addr_err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  assign addr_err = addr_err_q;
  assign rd_cnt   = rd_cnt_q;
  assign wr_cnt   = wr_cnt_q;

endmodule

// File: tb/tb_matmul_mem_port.sv
// Directed bench for matmul_mem_port: three instances (RD_LAT 1, 2, 4) share stimulus.
// Index 1 (RD_LAT=2) is the reference instance for most scenarios.
module tb_matmul_mem_port;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_write, host_req, host_write, err_clr, cnt_clr;
  logic [15:0] mem_addr, host_addr;
  logic [31:0] mem_wdata, host_wdata;

  logic [2:0]  mvld, hvld, gnt, aerr;
  logic [31:0] mdat [3];
  logic [31:0] hdat [3];
  logic [31:0] rcnt [3];
  logic [31:0] wcnt [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    matmul_mem_port #(
      .MEM_AW(16), .MEM_DW(32), .DEPTH(4096), .RD_LAT(LAT)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata_vld(mvld[gi]), .mem_rdata(mdat[gi]),
      .host_req(host_req), .host_write(host_write), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(gnt[gi]), .host_rdata_vld(hvld[gi]), .host_rdata(hdat[gi]),
      .addr_err(aerr[gi]), .err_clr(err_clr),
      .rd_cnt(rcnt[gi]), .wr_cnt(wcnt[gi]), .cnt_clr(cnt_clr)
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_req = 1'b0; mem_write = 1'b0; host_req = 1'b0; host_write = 1'b0;
    err_clr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
    host_req = 1'b1; host_write = 1'b1; host_addr = a; host_wdata = d;
    $display("host write addr=%0d data=%h", a, d);
    next();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle();
    mem_addr = '0; host_addr = '0; mem_wdata = '0; host_wdata = '0;
    repeat (3) next();
    checks++; if (mvld[1] !== 1'b0) begin errors++; $display("FAIL reset_mvld got %b exp 0", mvld[1]); end
    checks++; if (hvld[1] !== 1'b0) begin errors++; $display("FAIL reset_hvld got %b exp 0", hvld[1]); end
    checks++; if (mdat[1] !== 32'd0) begin errors++; $display("FAIL reset_mdat got %h exp 0", mdat[1]); end
    checks++; if (hdat[1] !== 32'd0) begin errors++; $display("FAIL reset_hdat got %h exp 0", hdat[1]); end
    checks++; if (aerr[1] !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", aerr[1]); end
    checks++; if (rcnt[1] !== 32'd0) begin errors++; $display("FAIL reset_rcnt got %0d exp 0", rcnt[1]); end
    checks++; if (wcnt[1] !== 32'd0) begin errors++; $display("FAIL reset_wcnt got %0d exp 0", wcnt[1]); end
    rst_n = 1'b1;
    next();
  endtask

  task automatic test_host_rw();
    logic ev;
    for (int i = 0; i < 4; i++) begin
      host_req = 1'b1; host_write = 1'b1; host_addr = 16'(i); host_wdata = 32'h11 + 32'(i);
      #1;
      checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL host_wr_gnt[%0d] got %b exp 1", i, gnt[1]); end
      $display("host write addr=%0d data=%h", i, host_wdata);
      next();
    end
    idle();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        host_req = 1'b1; host_write = 1'b0; host_addr = 16'(k);
        $display("host read addr=%0d", k);
      end else begin
        idle();
      end
      #1;
      ev = (k >= 2) && (k <= 5);
      checks++; if (hvld[1] !== ev) begin errors++; $display("FAIL host_rd_vld[%0d] got %b exp %b", k, hvld[1], ev); end
      if (ev) begin
        checks++; if (hdat[1] !== 32'h11 + 32'(k - 2)) begin errors++; $display("FAIL host_rd_data[%0d] got %h exp %h", k, hdat[1], 32'h11 + 32'(k - 2)); end
      end
      checks++; if (mvld[1] !== 1'b0) begin errors++; $display("FAIL host_rd_mvld[%0d] got %b exp 0", k, mvld[1]); end
      if (k == 6) begin
        checks++; if (hdat[1] !== 32'h14) begin errors++; $display("FAIL host_rd_hold got %h exp 14", hdat[1]); end
      end
      next();
    end
    checks++; if (rcnt[1] !== 32'd4) begin errors++; $display("FAIL host_rcnt got %0d exp 4", rcnt[1]); end
    checks++; if (wcnt[1] !== 32'd4) begin errors++; $display("FAIL host_wcnt got %0d exp 4", wcnt[1]); end
  endtask

  task automatic test_arbitration();
    host_wr(16'd5, 32'hA5);
    host_wr(16'd6, 32'hA6);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd5;
    host_req = 1'b1; host_write = 1'b0; host_addr = 16'd6;
    $display("engine read addr=5, host read addr=6 (contending)");
    #1;
    checks++; if (gnt[1] !== 1'b0) begin errors++; $display("FAIL arb_gnt_blocked got %b exp 0", gnt[1]); end
    next();
    mem_req = 1'b0;
    #1;
    checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL arb_gnt_next got %b exp 1", gnt[1]); end
    next();
    idle();
    #1;
    checks++; if (mvld[1] !== 1'b1) begin errors++; $display("FAIL arb_mvld got %b exp 1", mvld[1]); end
    checks++; if (mdat[1] !== 32'hA5) begin errors++; $display("FAIL arb_mdat got %h exp a5", mdat[1]); end
    checks++; if (hvld[1] !== 1'b0) begin errors++; $display("FAIL arb_hvld_early got %b exp 0", hvld[1]); end
    next();
    checks++; if (hvld[1] !== 1'b1) begin errors++; $display("FAIL arb_hvld got %b exp 1", hvld[1]); end
    checks++; if (hdat[1] !== 32'hA6) begin errors++; $display("FAIL arb_hdat got %h exp a6", hdat[1]); end
    checks++; if (mvld[1] !== 1'b0) begin errors++; $display("FAIL arb_mvld_host got %b exp 0", mvld[1]); end
    next();
  endtask

  task automatic test_raw();
    mem_req = 1'b1; mem_write = 1'b1; mem_addr = 16'd9; mem_wdata = 32'hDEAD;
    $display("engine write addr=9 data=dead");
    next();
    mem_write = 1'b0;
    $display("engine read addr=9");
    next();
    idle();
    #1;
    checks++; if (mvld[1] !== 1'b0) begin errors++; $display("FAIL raw_mvld_early got %b exp 0", mvld[1]); end
    next();
    checks++; if (mvld[1] !== 1'b1) begin errors++; $display("FAIL raw_mvld got %b exp 1", mvld[1]); end
    checks++; if (mdat[1] !== 32'hDEAD) begin errors++; $display("FAIL raw_mdat got %h exp dead", mdat[1]); end
    next();
  endtask

  task automatic test_out_of_range();
    host_wr(16'd904, 32'h904);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd4096;
    $display("engine read addr=4096");
    next();
    idle();
    #1;
    checks++; if (aerr[1] !== 1'b1) begin errors++; $display("FAIL oor_err_set got %b exp 1", aerr[1]); end
    next();
    checks++; if (mvld[1] !== 1'b1) begin errors++; $display("FAIL oor_mvld got %b exp 1", mvld[1]); end
    checks++; if (mdat[1] !== 32'd0) begin errors++; $display("FAIL oor_mdat got %h exp 0", mdat[1]); end
    checks++; if (aerr[1] !== 1'b1) begin errors++; $display("FAIL oor_err_sticky got %b exp 1", aerr[1]); end
    err_clr = 1'b1;
    next();
    err_clr = 1'b0;
    #1;
    checks++; if (aerr[1] !== 1'b0) begin errors++; $display("FAIL oor_err_clr got %b exp 0", aerr[1]); end
    host_req = 1'b1; host_write = 1'b1; host_addr = 16'd5000; host_wdata = 32'h5555;
    $display("host write addr=5000 data=5555");
    #1;
    checks++; if (gnt[1] !== 1'b1) begin errors++; $display("FAIL oor_host_gnt got %b exp 1", gnt[1]); end
    next();
    idle();
    #1;
    checks++; if (aerr[1] !== 1'b1) begin errors++; $display("FAIL oor_host_err got %b exp 1", aerr[1]); end
    host_req = 1'b1; host_write = 1'b0; host_addr = 16'd904;
    $display("host read addr=904");
    next();
    idle();
    next();
    checks++; if (hvld[1] !== 1'b1) begin errors++; $display("FAIL oor_alias_vld got %b exp 1", hvld[1]); end
    checks++; if (hdat[1] !== 32'h904) begin errors++; $display("FAIL oor_alias_data got %h exp 904", hdat[1]); end
    err_clr = 1'b1; mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd4096;
    $display("engine read addr=4096 with err_clr");
    next();
    idle();
    #1;
    checks++; if (aerr[1] !== 1'b1) begin errors++; $display("FAIL oor_err_wins got %b exp 1", aerr[1]); end
    err_clr = 1'b1;
    next();
    idle();
    repeat (4) next();
  endtask

  task automatic test_cnt_clr();
    cnt_clr = 1'b1; host_req = 1'b1; host_write = 1'b1; host_addr = 16'd20; host_wdata = 32'h20;
    $display("host write addr=20 with cnt_clr");
    next();
    idle();
    #1;
    checks++; if (rcnt[1] !== 32'd0) begin errors++; $display("FAIL cnt_clr_rcnt got %0d exp 0", rcnt[1]); end
    checks++; if (wcnt[1] !== 32'd0) begin errors++; $display("FAIL cnt_clr_wcnt got %0d exp 0", wcnt[1]); end
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd20;
    $display("engine read addr=20");
    next();
    idle();
    #1;
    checks++; if (rcnt[1] !== 32'd1) begin errors++; $display("FAIL cnt_after_rcnt got %0d exp 1", rcnt[1]); end
    checks++; if (wcnt[1] !== 32'd0) begin errors++; $display("FAIL cnt_after_wcnt got %0d exp 0", wcnt[1]); end
    repeat (5) next();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'(i);
      $display("engine read addr=%0d", i);
      next();
    end
    idle();
    rst_n = 1'b0;
    $display("reset asserted with reads in flight");
    #1;
    checks++; if (mvld !== 3'b000) begin errors++; $display("FAIL rstmid_in_reset_mvld got %b exp 000", mvld); end
    next();
    next();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (mvld !== 3'b000 || hvld !== 3'b000) begin errors++; $display("FAIL rstmid_vld[%0d] got m=%b h=%b exp 000", k, mvld, hvld); end
      next();
    end
    checks++; if (rcnt[1] !== 32'd0 || wcnt[1] !== 32'd0) begin errors++; $display("FAIL rstmid_cnt got r=%0d w=%0d exp 0", rcnt[1], wcnt[1]); end
    checks++; if (mdat[1] !== 32'd0) begin errors++; $display("FAIL rstmid_mdat got %h exp 0", mdat[1]); end
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 16'd9;
    $display("engine read addr=9 after reset");
    next();
    idle();
    next();
    checks++; if (mvld[1] !== 1'b1) begin errors++; $display("FAIL rstmid_retain_vld got %b exp 1", mvld[1]); end
    checks++; if (mdat[1] !== 32'hDEAD) begin errors++; $display("FAIL rstmid_retain_data got %h exp dead", mdat[1]); end
    next();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sweep_exp [16];
    logic [15:0] sweep_addr [16];
    logic        ev;
    int          lat;
    for (int n = 0; n < 16; n++) begin
      sweep_addr[n] = ((n % 2) == 1) ? 16'h200 + 16'(n / 2) : 16'h100 + 16'(n / 2);
      sweep_exp[n]  = ((n % 2) == 1) ? 32'hB000 + 32'(n / 2) : 32'hA000 + 32'(n / 2);
      mem_req = 1'b1; mem_write = 1'b1; mem_addr = sweep_addr[n]; mem_wdata = sweep_exp[n];
      $display("engine write addr=%h data=%h", sweep_addr[n], sweep_exp[n]);
      next();
    end
    idle();
    for (int k = 0; k < 21; k++) begin
      if (k < 16) begin
        mem_req = 1'b1; mem_write = 1'b0; mem_addr = sweep_addr[k];
        $display("engine read addr=%h", sweep_addr[k]);
      end else begin
        idle();
      end
      #1;
      for (int d = 0; d < 3; d++) begin
        lat = lat_of(d);
        ev  = (k >= lat) && (k < lat + 16);
        checks++; if (mvld[d] !== ev) begin errors++; $display("FAIL b2b_vld lat=%0d cyc=%0d got %b exp %b", lat, k, mvld[d], ev); end
        if (ev) begin
          checks++; if (mdat[d] !== sweep_exp[k - lat]) begin errors++; $display("FAIL b2b_data lat=%0d cyc=%0d got %h exp %h", lat, k, mdat[d], sweep_exp[k - lat]); end
        end
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_arbitration();
    test_raw();
    test_out_of_range();
    test_cnt_clr();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_mem_port.md
Name: matmul_mem_port

Overview:
- Word-addressed single-port SRAM subsystem that sits directly downstream of the matmul engine's memory request interface.
- Serves engine reads with a fixed latency and in-order return, and accepts engine writes.
- Exposes a secondary host port so matrices can be loaded and results read back.
- Arbitrates between the two ports. The engine port has absolute priority because it has no backpressure.

Parameters:
MEM_AW, 16, address width of both ports
MEM_DW, 32, data width
DEPTH, 4096, implemented words; valid addresses are 0..DEPTH-1 (DEPTH <= 2**MEM_AW)
RD_LAT, 2, read latency in cycles (>= 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
mem_req  in  1  engine request valid
mem_write  in  1  engine 1=write, 0=read
mem_addr  in  MEM_AW  engine word address
mem_wdata  in  MEM_DW  engine write data
mem_rdata_vld  out  1  engine read data valid (one cycle per read)
mem_rdata  out  MEM_DW  engine read data
host_req  in  1  host request valid (held until granted)
host_write  in  1  host 1=write, 0=read
host_addr  in  MEM_AW  host word address
host_wdata  in  MEM_DW  host write data
host_gnt  out  1  combinational grant; request accepted this cycle
host_rdata_vld  out  1  host read data valid
host_rdata  out  MEM_DW  host read data
addr_err  out  1  sticky out-of-range flag
err_clr  in  1  clears addr_err
rd_cnt  out  32  accepted reads, both ports
wr_cnt  out  32  accepted writes, both ports
cnt_clr  in  1  synchronous clear of rd_cnt and wr_cnt

Behaviour:
- Reset values: mem_rdata_vld=0, host_rdata_vld=0, mem_rdata=0, host_rdata=0, addr_err=0, rd_cnt=0, wr_cnt=0, read pipeline flushed. The array is not reset; contents are retained across rst_n.
- Arbitration, evaluated each cycle:
  - mem_req=1 always wins.
  - host_gnt = host_req & ~mem_req.
  - A host request that is not granted is held by the host. The block never drops an engine request.
- Access: exactly one access per cycle to the array, from the winning port.
  - Write: array[addr] <= wdata at the clock edge ending the cycle.
  - Read: sample array[addr] and enter the pipeline.
- Read pipeline: RD_LAT-stage shift register of {valid, src, data}, where src is 0=engine, 1=host.
  - A read accepted in cycle c produces vld=1 for exactly one cycle in cycle c+RD_LAT, on the port selected by src.
  - Data holds its last value when vld=0.
  - Returns are strictly in issue order. A back-to-back read stream at one per cycle gives a back-to-back vld stream.
  - The engine relies on this ordering: it alternates A and B operand reads.
- Read-after-write ordering: a write accepted in cycle c is visible to any read accepted in cycle c+1 or later. No same-cycle conflict is possible.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read still occupies its pipeline slot and returns data 0 with vld=1.
  - addr_err sets on the following edge.
- addr_err is sticky. err_clr=1 clears it. If err_clr and a new error occur in the same cycle, the error wins (flag stays 1).
- Counters:
  - Increment by 1 per accepted access, including out-of-range accesses.
  - Wrap at 2**32.
  - If cnt_clr and an access occur in the same cycle, the counter becomes 0; the access is not counted.
- Reset mid-operation: in-flight reads are discarded and no vld is produced after rst_n deasserts.
- Width: addresses are compared unsigned. The array index uses clog2(DEPTH) bits after the range check.

Test Plan:
- Host write 0x11..0x14 to 0..3, then host reads 0..3 back-to-back with RD_LAT=2 -> host_rdata_vld high in 4 consecutive cycles, starting 2 cycles after the first read, data 0x11..0x14; rd_cnt=4, wr_cnt=4.
- Engine read at 5 while host_req read at 6 in the same cycle -> host_gnt=0 in that cycle, granted in the next; mem_rdata_vld at c+2 and host_rdata_vld at c+3, each with the correct word; mem_rdata_vld never asserts for the host read.
- Engine write 0xDEAD to 9 in cycle c, engine read 9 in c+1 -> mem_rdata=0xDEAD at c+3.
- Engine read at DEPTH (4096) -> mem_rdata_vld=1 with data 0; addr_err=1 and stays 1. Pulse err_clr -> addr_err=0. A host write to 5000 is dropped and re-sets addr_err.
- Engine issues 3 reads, rst_n asserted one cycle later -> no vld on either port after reset; counters 0; a read of a pre-reset written address returns the old data.
- Sweep RD_LAT = 1, 2, 4 on 16 alternating A/B engine reads -> responses in order, exact latency, no bubbles.
